// File: rtl/glitch_sequencer.sv
//==============================================================================
// Module   : glitch_sequencer
// Purpose  : Armed, edge-triggered multi-pulse glitch generator with
//            programmable delay, pulse width, gap, count and output polarity.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module glitch_sequencer #(
    parameter int CNT_W      = 32,
    parameter int PCNT_W     = 8,
    parameter int OUT_ACTIVE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    input  logic              trig_pol,
    input  logic              auto_rearm,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  gap,
    input  logic [PCNT_W-1:0] count,
    output logic              glitch_out,
    output logic              armed,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] pulses_left
);

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_armed = 3'd1;
    localparam logic [2:0] c_s_delay = 3'd2;
    localparam logic [2:0] c_s_pulse = 3'd3;
    localparam logic [2:0] c_s_gap   = 3'd4;

    localparam logic [CNT_W-1:0]  c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PCNT_W-1:0] c_pl_one  = {{(PCNT_W-1){1'b0}}, 1'b1};
    localparam logic              c_on      = (OUT_ACTIVE != 0);
    localparam logic              c_off     = !c_on;

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PCNT_W-1:0] r_pl;
    logic              r_done;
    logic              r_glitch;
    logic              r_armed;
    logic              r_busy;
    logic              r_trig_q;

    logic [CNT_W-1:0]  r_delay;
    logic [CNT_W-1:0]  r_width;
    logic [CNT_W-1:0]  r_gap;
    logic [PCNT_W-1:0] r_count;
    logic              r_pol;
    logic              r_rearm;

    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PCNT_W-1:0] w_pl_nxt;
    logic              w_done_nxt;
    logic              w_start;
    logic              w_finish;
    logic              w_edge;
    logic              w_arm_ok;

    assign w_edge   = (trig != r_trig_q) && (trig == r_pol);
    assign w_arm_ok = (r_state == c_s_idle) && arm && !abort;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pl_nxt    = r_pl;
        w_done_nxt  = 1'b0;
        w_start     = 1'b0;
        w_finish    = 1'b0;

        case (r_state)
            c_s_idle: begin
                if (arm) w_state_nxt = c_s_armed;
            end
            c_s_armed: begin
                if (w_edge) begin
                    w_pl_nxt = r_count;
                    if (r_delay == '0) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_nxt = c_s_delay;
                        w_cnt_nxt   = r_delay - c_cnt_one;
                    end
                end
            end
            c_s_delay, c_s_gap: begin
                if (r_cnt == '0) w_start = 1'b1;
                else             w_cnt_nxt = r_cnt - c_cnt_one;
            end
            c_s_pulse: begin
                if (r_cnt == '0) begin
                    w_pl_nxt = r_pl - c_pl_one;
                    if (r_pl > c_pl_one) begin
                        // Zero gap chains straight into the next pulse.
                        if (r_gap == '0) begin
                            w_cnt_nxt = r_width - c_cnt_one;
                        end else begin
                            w_state_nxt = c_s_gap;
                            w_cnt_nxt   = r_gap - c_cnt_one;
                        end
                    end else begin
                        w_finish = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: w_state_nxt = c_s_idle;
        endcase

        if (w_start) begin
            if ((r_count == '0) || (r_width == '0)) begin
                w_finish = 1'b1;
            end else begin
                w_state_nxt = c_s_pulse;
                w_cnt_nxt   = r_width - c_cnt_one;
            end
        end

        if (w_finish) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = r_rearm ? c_s_armed : c_s_idle;
        end

        if (abort) begin
            w_state_nxt = c_s_idle;
            w_cnt_nxt   = '0;
            w_pl_nxt    = '0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_s_idle;
            r_cnt    <= '0;
            r_pl     <= '0;
            r_done   <= 1'b0;
            r_glitch <= c_off;
            r_armed  <= 1'b0;
            r_busy   <= 1'b0;
            r_trig_q <= 1'b0;
            r_delay  <= '0;
            r_width  <= '0;
            r_gap    <= '0;
            r_count  <= '0;
            r_pol    <= 1'b0;
            r_rearm  <= 1'b0;
        end else begin
            r_trig_q <= trig;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pl     <= w_pl_nxt;
            r_done   <= w_done_nxt;
            r_glitch <= (w_state_nxt == c_s_pulse) ? c_on : c_off;
            r_armed  <= (w_state_nxt == c_s_armed);
            r_busy   <= (w_state_nxt == c_s_delay) || (w_state_nxt == c_s_pulse) ||
                        (w_state_nxt == c_s_gap);
            if (w_arm_ok) begin
                r_delay <= delay;
                r_width <= width;
                r_gap   <= gap;
                r_count <= count;
                r_pol   <= trig_pol;
                r_rearm <= auto_rearm;
            end
        end
    end

    assign glitch_out  = r_glitch;
    assign armed       = r_armed;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pulses_left = r_pl;

endmodule

`default_nettype wire

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Armed, trigger-driven multi-pulse glitch generator; parametrised successor to the single-shot delay/duty pulse logic. After a qualified trigger edge it waits a programmable delay, then emits a programmable number of pulses of programmable width and gap. Output polarity and auto-rearm are selectable. Sits between the synchronised target trigger input and the glitch driver; config comes from host registers.

Parameters:
CNT_W, 32, width of delay/width/gap counters and config fields
PCNT_W, 8, width of pulse-count field (max 2^PCNT_W-1 pulses)
OUT_ACTIVE, 1, active level of glitch_out (1 = active-high)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
arm  in  1  single-cycle request: latch config, enter ARMED
abort  in  1  synchronous abort, highest priority after reset
trig  in  1  trigger input, already synchronised to clk
trig_pol  in  1  1 = rising edge qualifies, 0 = falling edge
auto_rearm  in  1  1 = return to ARMED after sequence, 0 = IDLE
delay  in  CNT_W  cycles from trigger detect to first pulse
width  in  CNT_W  active cycles per pulse
gap  in  CNT_W  inactive cycles between pulses
count  in  PCNT_W  number of pulses
glitch_out  out  1  registered glitch drive
armed  out  1  high in ARMED
busy  out  1  high in DELAY, PULSE, GAP
done  out  1  one-cycle pulse at sequence end
pulses_left  out  PCNT_W  pulses remaining incl. current

Behaviour:
- Reset (rst_n low, async): state IDLE; glitch_out = ~OUT_ACTIVE; armed, busy, done = 0; pulses_left = 0; config shadows and counters 0; trig history register 0.
- All outputs registered. States: IDLE, ARMED, DELAY, PULSE, GAP.
- Config (delay, width, gap, count, trig_pol, auto_rearm) latched into shadows on accepted arm; live inputs ignored otherwise. arm accepted only in IDLE; ignored elsewhere.
- Edge detect: trig_q <= trig every cycle. Qualified edge at cycle T when trig != trig_q and trig == trig_pol (shadow). Edges evaluated only in ARMED; an edge in the cycle arm is accepted is ignored.
- ARMED -> DELAY at T. glitch_out first active in cycle T+delay+1 (delay=0: active in T+1).
- PULSE: glitch_out active exactly width cycles. Then if pulses_left>1 -> GAP (gap cycles inactive) -> PULSE; gap=0 goes straight to next PULSE (output stays active, pulses merge).
- pulses_left loads count at T, decrements on the last cycle of each pulse.
- After last pulse's final active cycle: next cycle glitch_out inactive, done=1 for one cycle, state -> ARMED (auto_rearm=1, shadows retained) or IDLE.
- count=0 or width=0: no active output; done asserted in cycle T+delay+1, then rearm/idle as above.
- Counters compare in CNT_W unsigned; no wrap: delay=2^CNT_W-1 legal.
- Trigger edges during DELAY/PULSE/GAP ignored (no retrigger, no queueing).
- abort in any state: next cycle state IDLE, glitch_out inactive, armed=busy=0, done=0, pulses_left=0. abort and arm same cycle: abort wins.
- busy = DELAY|PULSE|GAP; armed = ARMED.
- OUT_ACTIVE=0 inverts glitch_out only; all timing identical.

Test Plan:
- Reset mid-PULSE (rst_n low 1 cycle) -> glitch_out inactive immediately (async), state IDLE, done never asserted.
- delay=5, width=3, gap=2, count=3, trig_pol=1, rising trig at T -> glitch_out high T+6..T+8, T+11..T+13, T+16..T+18; done=1 at T+19; pulses_left 3,2,1,0.
- trig_pol=0, delay=0, width=1, count=1, auto_rearm=1 -> rising edge ignored; falling edge at T gives high T+1 only, done T+2, armed=1 T+2; second falling edge repeats without new arm.
- count=0, delay=4 -> glitch_out never active, done at T+5; width=4, gap=0, count=2 -> continuous high 8 cycles.
- abort during GAP of count=4 sequence -> next cycle IDLE, no further pulses; arm during busy ignored (config change has no effect on running sequence).
- OUT_ACTIVE=0, delay=1, width=2, count=1 -> glitch_out low T+2..T+3, high otherwise, including reset value.
